// File: rtl/vga_object_compositor.sv
// VGA timing generator compositing grid-aligned sprite objects over an external background.
// Optional player-vs-object cell collision detector enabled by defining VGA_COLLISION_EN.
module vga_object_compositor #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int N_OBJ     = 16,
  parameter int CELL_LOG2 = 5,
  parameter int COL_W     = 5,
  parameter int ROW_W     = 4,
  parameter int KIND_W    = 2,
  parameter int IDX_W     = $clog2(N_OBJ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 obj_wr_en,
  input  logic [IDX_W-1:0]     obj_wr_idx,
  input  logic [COL_W-1:0]     obj_wr_col,
  input  logic [ROW_W-1:0]     obj_wr_row,
  input  logic [KIND_W-1:0]    obj_wr_kind,
  input  logic                 obj_wr_vis,
  output logic [KIND_W-1:0]    spr_kind,
  output logic [CELL_LOG2-1:0] spr_x,
  output logic [CELL_LOG2-1:0] spr_y,
  input  logic [5:0]           spr_pixel,
  output logic [9:0]           h_count,
  output logic [9:0]           v_count,
  input  logic [8:0]           bg_rgb,
  output logic [2:0]           vga_r,
  output logic [2:0]           vga_g,
  output logic [2:0]           vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 frame_start,
  output logic                 collide,
  output logic [IDX_W-1:0]     collide_idx
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_SWAP   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int unsigned COL_LIM = H_ACTIVE >> CELL_LOG2;

  logic [9:0] r_h, r_v;
  logic       w_swap, w_active, w_hs, w_vs;
  logic [9:0] w_col, w_row;

  logic [COL_W-1:0]  r_pnd_col  [N_OBJ];
  logic [ROW_W-1:0]  r_pnd_row  [N_OBJ];
  logic [KIND_W-1:0] r_pnd_kind [N_OBJ];
  logic              r_pnd_vis  [N_OBJ];
  logic [COL_W-1:0]  r_act_col  [N_OBJ];
  logic [ROW_W-1:0]  r_act_row  [N_OBJ];
  logic [KIND_W-1:0] r_act_kind [N_OBJ];
  logic              r_act_vis  [N_OBJ];

  logic              w_hit;
  logic [KIND_W-1:0] w_kind;

  logic                 r_hit1, r_act1, r_hs1, r_vs1;
  logic [KIND_W-1:0]    r_kind1;
  logic [CELL_LOG2-1:0] r_sx, r_sy;
  logic                 r_act2, r_hs2, r_vs2;
  logic [8:0]           r_rgb2;
  logic [2:0]           r_vga_r, r_vga_g, r_vga_b;
  logic                 r_hs3, r_vs3, r_frame;

  assign w_swap   = (r_h == H_LAST) && (r_v == V_SWAP);
  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs     = !((r_h >= HS_START) && (r_h < HS_END));
  assign w_vs     = !((r_v >= VS_START) && (r_v < VS_END));
  assign w_col    = r_h >> CELL_LOG2;
  assign w_row    = r_v >> CELL_LOG2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
    end else begin
      r_h <= r_h + 10'd1;
    end
  end

  // Swap copies the old pending contents; a write on the swap cycle stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_OBJ; k++) begin
        r_pnd_col[k]  <= '0;
        r_pnd_row[k]  <= '0;
        r_pnd_kind[k] <= '0;
        r_pnd_vis[k]  <= 1'b0;
        r_act_col[k]  <= '0;
        r_act_row[k]  <= '0;
        r_act_kind[k] <= '0;
        r_act_vis[k]  <= 1'b0;
      end
    end else begin
      if (w_swap) begin
        for (int unsigned k = 0; k < N_OBJ; k++) begin
          r_act_col[k]  <= r_pnd_col[k];
          r_act_row[k]  <= r_pnd_row[k];
          r_act_kind[k] <= r_pnd_kind[k];
          r_act_vis[k]  <= r_pnd_vis[k];
        end
      end
      if (obj_wr_en) begin
        r_pnd_col[obj_wr_idx]  <= obj_wr_col;
        r_pnd_row[obj_wr_idx]  <= obj_wr_row;
        r_pnd_kind[obj_wr_idx] <= obj_wr_kind;
        r_pnd_vis[obj_wr_idx]  <= obj_wr_vis;
      end
    end
  end

  always_comb begin
    w_hit  = 1'b0;
    w_kind = '0;
    for (int unsigned k = 0; k < N_OBJ; k++) begin
      if (!w_hit && r_act_vis[k] && (10'(r_act_col[k]) == w_col) &&
          (10'(r_act_row[k]) == w_row) && (32'(r_act_col[k]) < COL_LIM)) begin
        w_hit  = 1'b1;
        w_kind = r_act_kind[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit1  <= 1'b0;
      r_act1  <= 1'b0;
      r_hs1   <= 1'b1;
      r_vs1   <= 1'b1;
      r_kind1 <= '0;
      r_sx    <= '0;
      r_sy    <= '0;
      r_act2  <= 1'b0;
      r_hs2   <= 1'b1;
      r_vs2   <= 1'b1;
      r_rgb2  <= '0;
      r_vga_r <= '0;
      r_vga_g <= '0;
      r_vga_b <= '0;
      r_hs3   <= 1'b1;
      r_vs3   <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_hit1  <= w_hit;
      r_act1  <= w_active;
      r_hs1   <= w_hs;
      r_vs1   <= w_vs;
      r_kind1 <= w_kind;
      r_sx    <= r_h[CELL_LOG2-1:0];
      r_sy    <= r_v[CELL_LOG2-1:0];
      r_act2  <= r_act1;
      r_hs2   <= r_hs1;
      r_vs2   <= r_vs1;
      // A transparent sprite pixel shows background, never a lower-priority slot.
      r_rgb2  <= (r_hit1 && (spr_pixel != 6'd0)) ?
                 {spr_pixel[5:4], 1'b0, spr_pixel[3:2], 1'b0, spr_pixel[1:0], 1'b0} : bg_rgb;
      r_vga_r <= r_act2 ? r_rgb2[8:6] : '0;
      r_vga_g <= r_act2 ? r_rgb2[5:3] : '0;
      r_vga_b <= r_act2 ? r_rgb2[2:0] : '0;
      r_hs3   <= r_hs2;
      r_vs3   <= r_vs2;
      r_frame <= w_swap;
    end
  end

`ifdef VGA_COLLISION_EN
  logic             w_chit;
  logic [IDX_W-1:0] w_cidx;
  logic             r_cflag, r_collide;
  logic [IDX_W-1:0] r_cidx, r_collide_idx;

  always_comb begin
    w_chit = 1'b0;
    w_cidx = '0;
    for (int unsigned k = 1; k < N_OBJ; k++) begin
      if (!w_chit && r_act_vis[0] && r_act_vis[k] &&
          (r_act_col[k] == r_act_col[0]) && (r_act_row[k] == r_act_row[0])) begin
        w_chit = 1'b1;
        w_cidx = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cflag       <= 1'b0;
      r_cidx        <= '0;
      r_collide     <= 1'b0;
      r_collide_idx <= '0;
    end else if (w_swap) begin
      r_collide     <= r_cflag;
      r_collide_idx <= r_cflag ? r_cidx : '0;
      r_cflag       <= 1'b0;
    end else begin
      r_collide <= 1'b0;
      if (w_active && w_chit && (!r_cflag || (w_cidx < r_cidx))) begin
        r_cflag <= 1'b1;
        r_cidx  <= w_cidx;
      end
    end
  end

  assign collide     = r_collide;
  assign collide_idx = r_collide_idx;
`else
  assign collide     = 1'b0;
  assign collide_idx = '0;
`endif

  assign h_count     = r_h;
  assign v_count     = r_v;
  assign spr_kind    = r_kind1;
  assign spr_x       = r_sx;
  assign spr_y       = r_sy;
  assign vga_r       = r_vga_r;
  assign vga_g       = r_vga_g;
  assign vga_b       = r_vga_b;
  assign vga_hs      = r_hs3;
  assign vga_vs      = r_vs3;
  assign frame_start = r_frame;

endmodule

// File: tb/tb_vga_object_compositor.sv
// Bench for vga_object_compositor on a reduced raster, checked against a per-pixel reference model.
module tb_vga_object_compositor;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int N = 16, CL = 3, CW = 5, RW = 4, KW = 2, IW = 4;
  localparam int CELL = 1 << CL;

  logic          clk = 1'b0;
  logic          rst;
  logic          obj_wr_en;
  logic [IW-1:0] obj_wr_idx;
  logic [CW-1:0] obj_wr_col;
  logic [RW-1:0] obj_wr_row;
  logic [KW-1:0] obj_wr_kind;
  logic          obj_wr_vis;
  logic [KW-1:0] spr_kind;
  logic [CL-1:0] spr_x, spr_y;
  logic [5:0]    spr_pixel;
  logic [9:0]    h_count, v_count;
  logic [8:0]    bg_rgb;
  logic [2:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, frame_start, collide;
  logic [IW-1:0] collide_idx;
  logic [9:0]    hd, vd;

  vga_object_compositor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .N_OBJ(N), .CELL_LOG2(CL), .COL_W(CW), .ROW_W(RW), .KIND_W(KW), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .obj_wr_en(obj_wr_en), .obj_wr_idx(obj_wr_idx), .obj_wr_col(obj_wr_col),
    .obj_wr_row(obj_wr_row), .obj_wr_kind(obj_wr_kind), .obj_wr_vis(obj_wr_vis),
    .spr_kind(spr_kind), .spr_x(spr_x), .spr_y(spr_y), .spr_pixel(spr_pixel),
    .h_count(h_count), .v_count(v_count), .bg_rgb(bg_rgb),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_start(frame_start), .collide(collide), .collide_idx(collide_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] rom_f(input int kind, input int x, input int y);
    case (kind)
      1:       return 6'b110000;
      0:       return ((x + y) % 2 == 0) ? 6'b001101 : 6'd0;
      default: return 6'((kind * 11 + x * 3 + y * 5) % 64);
    endcase
  endfunction

  function automatic logic [8:0] bg_f(input int h, input int v);
    return 9'((h * 5 + v * 17 + 3) % 512);
  endfunction

  // External ROM: combinational off the registered fetch address. Background: one register after the counters.
  assign spr_pixel = rom_f(int'(spr_kind), int'(spr_x), int'(spr_y));
  assign bg_rgb    = bg_f(int'(hd), int'(vd));
  always @(posedge clk) begin
    hd <= h_count;
    vd <= v_count;
  end

  typedef struct { logic [8:0] rgb; logic hs; logic vs; } exp_t;
  exp_t q[$];
  int   cyc;
  int   n_checks = 0, n_errors = 0;
  int   mp_col[N], mp_row[N], mp_kind[N], mp_vis[N];
  int   ma_col[N], ma_row[N], ma_kind[N], ma_vis[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_t r;
    r.rgb = '0; r.hs = 1'b1; r.vs = 1'b1;
    for (int k = 0; k < N; k++) begin
      mp_col[k] = 0; mp_row[k] = 0; mp_kind[k] = 0; mp_vis[k] = 0;
      ma_col[k] = 0; ma_row[k] = 0; ma_kind[k] = 0; ma_vis[k] = 0;
    end
    cyc = 0;
    q.delete();
    q.push_back(r);
    q.push_back(r);
  endtask

  task automatic reset_checks();
    check("rst_h", 32'(h_count), 0);
    check("rst_v", 32'(v_count), 0);
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    check("rst_sync", 32'({vga_hs, vga_vs}), 3);
    check("rst_spr", 32'({spr_kind, spr_x, spr_y}), 0);
    check("rst_frame", 32'(frame_start), 0);
    check("rst_coll", 32'({collide, collide_idx}), 0);
  endtask

  task automatic tick();
    int mh, mv, win, wk, eci;
    logic [5:0] p;
    logic sw, ec;
    exp_t e;
    mh = cyc % HT;
    mv = (cyc / HT) % VT;
    check("h_count", 32'(h_count), 32'(mh));
    check("v_count", 32'(v_count), 32'(mv));
    win = -1; wk = 0;
    for (int k = 0; k < N; k++)
      if (win < 0 && ma_vis[k] != 0 && ma_col[k] == mh / CELL && ma_row[k] == mv / CELL &&
          ma_col[k] < HA / CELL) begin
        win = k; wk = ma_kind[k];
      end
    e.rgb = bg_f(mh, mv);
    if (win >= 0) begin
      p = rom_f(wk, mh % CELL, mv % CELL);
      if (p != 6'd0) e.rgb = {p[5:4], 1'b0, p[3:2], 1'b0, p[1:0], 1'b0};
    end
    if (!(mh < HA && mv < VA)) e.rgb = '0;
    e.hs = !(mh >= HA + HF && mh < HA + HF + HS);
    e.vs = !(mv >= VA + VF && mv < VA + VF + VS);
    q.push_back(e);
    sw = (mh == HT - 1 && mv == VA - 1);
    ec = 1'b0; eci = 0;
`ifdef VGA_COLLISION_EN
    if (sw && ma_vis[0] != 0)
      for (int k = 1; k < N; k++)
        if (!ec && ma_vis[k] != 0 && ma_col[k] == ma_col[0] && ma_row[k] == ma_row[0]) begin
          ec = 1'b1; eci = k;
        end
`endif
    if (sw)
      for (int k = 0; k < N; k++) begin
        ma_col[k] = mp_col[k]; ma_row[k] = mp_row[k]; ma_kind[k] = mp_kind[k]; ma_vis[k] = mp_vis[k];
      end
    if (obj_wr_en) begin
      mp_col[obj_wr_idx] = int'(obj_wr_col); mp_row[obj_wr_idx] = int'(obj_wr_row);
      mp_kind[obj_wr_idx] = int'(obj_wr_kind); mp_vis[obj_wr_idx] = int'(obj_wr_vis);
    end
    @(posedge clk); #1;
    cyc++;
    if (q.size() == 3) begin
      e = q.pop_front();
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
      check("sync", 32'({vga_hs, vga_vs}), 32'({e.hs, e.vs}));
    end
    check("frame_start", 32'(frame_start), 32'(sw));
    check("collide", 32'(collide), 32'(ec));
    if (ec) check("collide_idx", 32'(collide_idx), 32'(eci));
    check("spr_x", 32'(spr_x), 32'(mh % CELL));
    check("spr_y", 32'(spr_y), 32'(mv % CELL));
    if (win >= 0) check("spr_kind", 32'(spr_kind), 32'(wk));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int h, input int v);
    for (int i = 0; i < HT * VT; i++) begin
      if (cyc % HT == h && (cyc / HT) % VT == v) return;
      tick();
    end
    check("run_until_timeout", 1, 0);
  endtask

  task automatic wr(input int idx, input int col, input int row, input int kind, input int vis);
    obj_wr_en = 1'b1; obj_wr_idx = IW'(idx); obj_wr_col = CW'(col);
    obj_wr_row = RW'(row); obj_wr_kind = KW'(kind); obj_wr_vis = vis[0];
    tick();
    obj_wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    obj_wr_en = 1'b0; obj_wr_idx = '0; obj_wr_col = '0;
    obj_wr_row = '0; obj_wr_kind = '0; obj_wr_vis = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b0;
    model_reset();

    run(2 * HT * VT);
    wr(3, 2, 1, 1, 1);
    run(HT * VT + 100);
    wr(0, 4, 4, 0, 1);
    wr(5, 4, 4, 2, 1);
    run(HT * VT + 100);
    wr(7, 4, 4, 3, 1);
    wr(2, 4, 4, 2, 1);
    run(HT * VT);
    run_until(0, 20);
    wr(3, 7, 1, 1, 1);
    wr(6, 9, 2, 2, 1);
    run(HT * VT);
    wr(0, 1, 5, 0, 1);
    run(HT * VT + 50);

    for (int i = 0; i < 2 * HT * VT; i++) begin
      if ($urandom_range(0, 7) == 0)
        wr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 10)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3) != 0));
      else tick();
    end

    run_until(30, 20);
    rst = 1'b1;
    #1;
    reset_checks();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run(HT * VT + 200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/vga_object_compositor.md
# vga_object_compositor

Parametrised successor to the game's VGA display path. Generates VGA timing and composites up to N_OBJ grid-aligned sprite objects over an external background, using one shared external sprite-ROM fetch port and a fixed pipeline latency. The object table is double-buffered and swapped once per frame, so the game FSM can update positions at any time without tearing. An optional player-vs-object cell collision detector is included.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- N_OBJ, 16, object slots; slot 0 is the player
- CELL_LOG2, 5, log2 of the cell size (32×32 pixels)
- COL_W, 5, column field width
- ROW_W, 4, row field width
- KIND_W, 2, sprite-kind field width
- IDX_W, $clog2(N_OBJ), slot index width
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- obj_wr_en  in  1  write one slot of the pending table this cycle
- obj_wr_idx  in  IDX_W  slot written
- obj_wr_col / obj_wr_row  in  COL_W / ROW_W  cell position
- obj_wr_kind  in  KIND_W  sprite kind (selects the ROM image)
- obj_wr_vis  in  1  slot visible
- spr_kind  out  KIND_W  ROM fetch: kind
- spr_x / spr_y  out  CELL_LOG2 each  ROM fetch: pixel offset inside the cell
- spr_pixel  in  6  ROM data RRGGBB, 1-cycle latency; 0 = transparent
- h_count  out  10  raw horizontal counter
- v_count  out  10  raw vertical counter
- bg_rgb  in  9  background RGB for (h_count, v_count), 2-cycle latency
- vga_r / vga_g / vga_b  out  3 each  registered colour
- vga_hs / vga_vs  out  1 each  sync, active low
- frame_start  out  1  one-cycle pulse when the table swap occurs
- collide  out  1  one-cycle pulse, one frame of detection
- collide_idx  out  IDX_W  lowest colliding slot

## Operation
- Horizontal order: h 0..H_ACTIVE-1 is active, followed by FP, SYNC, then BP. H_TOTAL is the sum.
- Vertical order follows the same pattern (active, FP, SYNC, BP) and advances when h wraps to 0.
- Both counters wrap to 0 at their totals.
- Pending table is written by obj_wr_*. Active table is read by the raster.
- Swap: on the cycle with h=H_TOTAL-1 and v=V_ACTIVE-1, active ← pending and frame_start pulses.
  - A write on that same cycle lands in pending only.
  - That write is applied at the next swap.
- Stage 1, from the counters: compute the cell as col = h>>CELL_LOG2 and row = v>>CELL_LOG2.
  - Compare the cell against all visible active slots.
  - The winner is the lowest matching index.
  - Register hit, winner kind, spr_x = h[CELL_LOG2-1:0] and spr_y = v[CELL_LOG2-1:0].
- Stage 2:
  - If there is no hit, use bg_rgb.
  - If spr_pixel == 0, use bg_rgb. There is no fallthrough to a lower-priority slot.
  - Otherwise use {spr_pixel[5:4],0}, {spr_pixel[3:2],0}, {spr_pixel[1:0],0}.
- Stage 3: register the output. Colour is 0 outside the active area.
- Cells with col ≥ H_ACTIVE>>CELL_LOG2 never match.

## Timing
- Counter value at edge t produces vga_r/g/b at t+3.
- vga_hs and vga_vs are delayed 3 cycles to stay aligned with colour.
- spr_kind, spr_x and spr_y are valid at t+1.
- bg_rgb is sampled at t+2.
- Reset values:
  - Counters 0.
  - All slots, pending and active: vis 0, col 0, row 0, kind 0.
  - vga_r/g/b 0; vga_hs 1; vga_vs 1.
  - spr_* 0; frame_start 0; collide 0; collide_idx 0.
- Reset asserted mid-frame clears all of the above asynchronously. Timing restarts at h=0, v=0 on the first edge after release.
- obj_wr_en needs no handshake and is accepted on every cycle. Back-to-back writes to the same slot: the last one wins.

## Configuration
- Macro: VGA_COLLISION_EN.
- With the macro defined, during active video:
  - If slot 0 is visible and its cell equals the cell of any other visible slot, set a sticky flag.
  - Latch the lowest such slot index seen this frame.
  - At the swap, collide pulses if the flag is set, collide_idx is valid with it, and the flag clears.
- Without the macro, no comparator logic is built, and collide and collide_idx are tied to 0.

## Test plan
- Reset, then run 2 frames:
  - hs low for 96 clocks per 800-clock line.
  - vs low for 2 of 525 lines.
  - rgb equals bg_rgb inside the active area and 0 outside.
- Write slot 3 (col 2, row 1, kind 1, vis) and return ROM value 6'b110000:
  - Pixels (64..95, 32..63) output r=6, g=0, b=0 with 3-cycle latency.
  - spr_kind = 1 in that region.
- Slots 0 and 5 both at col 4, row 4:
  - Slot 0's kind is fetched.
  - Where the ROM returns 0, bg_rgb appears. Slot 5 never shows.
- Write slot 3 at col 9 mid-frame: the old position is drawn until the swap, and the new position is drawn from the next frame.
- With VGA_COLLISION_EN, slots 0, 7 and 2 at the same cell: one collide pulse per frame with collide_idx=2. After moving slot 0 away, no pulse.
- Assert rst at h=300, v=200 for 1 cycle: all outputs return to their reset values immediately, and frame timing restarts from 0.
